coin_acceptor: RTL and testbench

//  Front-end stage feeding the coffee vending fsm. Conditions three raw, asynchronous, bouncy coin-slot

---
 rtl/coin_acceptor_pkg.sv | 41 ++++
 rtl/coin_acceptor_sync_chain.sv | 30 +++
 rtl/coin_acceptor.sv | 115 +++++++++++
 tb/tb_coin_acceptor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared types for the coin acceptor: FSM state encoding, coin codes and the
// output pulse bundle with its decode rule.
package coin_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      EMIT     = 3'd2,
      RELEASE  = 3'd3,
      GAP      = 3'd4
   } acc_state_t;

   localparam logic [2:0] COIN_50  = 3'b001;
   localparam logic [2:0] COIN_100 = 3'b010;
   localparam logic [2:0] COIN_200 = 3'b100;

   typedef struct packed {
      logic reject;
      logic r200;
      logic r100;
      logic r50;
   } pulse_t;

   // A single clean coin is credited only when the fsm accepts; everything else is returned.
   function automatic pulse_t pulse_decode(input logic [2:0] code, input logic accept);
      pulse_t p;
      p = '0;
      if (!accept) begin
         p.reject = 1'b1;
      end else begin
         case (code)
            COIN_50:  p.r50    = 1'b1;
            COIN_100: p.r100   = 1'b1;
            COIN_200: p.r200   = 1'b1;
            default:  p.reject = 1'b1;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/coin_acceptor_sync_chain.sv
// Single-bit metastability synchroniser: STAGES flops in series, cleared by
// the asynchronous active-low reset.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces three raw sensors and emits
// one registered credit or reject pulse per inserted coin.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_50_raw,
   input  logic       coin_100_raw,
   input  logic       coin_200_raw,
   input  logic       accept_en,
   output logic       r50,
   output logic       r100,
   output logic       r200,
   output logic       reject,
   output logic [2:0] state
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [2:0] raw;
   logic [2:0] s;

   assign raw = {coin_200_raw, coin_100_raw, coin_50_raw};

   for (genvar i = 0; i < 3; i++) begin : g_sync
      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (raw[i]),
         .q   (s[i])
      );
   end

   acc_state_t       state_q, state_d;
   logic [2:0]       code_q,  code_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   pulse_t           pulse_q, pulse_d;

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can infer a latch.
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      case (state_q)
         IDLE: begin
            if (s != 3'b000) begin
               state_d = DEBOUNCE;
               code_d  = s;
               cnt_d   = CNT_ONE;
            end
         end
         DEBOUNCE: begin
            if (s == 3'b000) begin
               state_d = IDLE;
            end else if (s != code_q) begin
               code_d = s;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = EMIT;
               pulse_d = pulse_decode(code_q, accept_en);
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         EMIT: begin
            state_d = RELEASE;
            cnt_d   = '0;
         end
         // A coin still present keeps restarting the release count, so it can never re-emit.
         RELEASE: begin
            if (s != 3'b000) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign r50    = pulse_q.r50;
   assign r100   = pulse_q.r100;
   assign r200   = pulse_q.r200;
   assign reject = pulse_q.reject;
   assign state  = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized coin
// windows scored against a per-coin outcome model.
module tb_coin_acceptor;
   import coin_pkg::*;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LOW  = 2 * DEB + SYNC + 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_50_raw = 1'b0;
   logic       coin_100_raw = 1'b0;
   logic       coin_200_raw = 1'b0;
   logic       accept_en = 1'b0;
   logic       r50, r100, r200, reject;
   logic [2:0] state;

   int tests  = 0;
   int failed = 0;

   coin_acceptor #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_50_raw  (coin_50_raw),
      .coin_100_raw (coin_100_raw),
      .coin_200_raw (coin_200_raw),
      .accept_en    (accept_en),
      .r50          (r50),
      .r100         (r100),
      .r200         (r200),
      .reject       (reject),
      .state        (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   int   n50, n100, n200, nrej, overlap, adjacent, first_cyc;
   logic prev_any = 1'b0;
   always @(negedge clk) begin
      logic any;
      any = r50 | r100 | r200 | reject;
      if (r50)    n50++;
      if (r100)   n100++;
      if (r200)   n200++;
      if (reject) nrej++;
      if ($countones({r50, r100, r200, reject}) > 1) overlap++;
      if (any && prev_any) adjacent++;
      if (any && first_cyc < 0) first_cyc = cyc;
      prev_any = any;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic reset_counts();
      n50 = 0; n100 = 0; n200 = 0; nrej = 0;
      overlap = 0; adjacent = 0; first_cyc = -1;
   endtask

   task automatic set_raw(input logic [2:0] bits);
      {coin_200_raw, coin_100_raw, coin_50_raw} = bits;
   endtask

   task automatic coin_window(input logic [2:0] bits, input int hold, input int low, input logic acc);
      accept_en = acc;
      set_raw(bits);
      tick(hold);
      set_raw(3'b000);
      tick(low);
   endtask

   // Outcome of one isolated coin window, derived from the rules: the code must be seen
   // for DEB+1 consecutive sampled cycles; one clean coin + accept credits, else reject.
   function automatic void model(input logic [2:0] bits, input int hold, input logic acc,
                                 output int e50, output int e100, output int e200, output int erej);
      e50 = 0; e100 = 0; e200 = 0; erej = 0;
      if (bits == 3'b000 || hold < DEB + 1) return;
      if ($countones(bits) == 1 && acc) begin
         if (bits[0]) e50 = 1;
         if (bits[1]) e100 = 1;
         if (bits[2]) e200 = 1;
      end else begin
         erej = 1;
      end
   endfunction

   task automatic check_counts(input string name, input int e50, input int e100, input int e200, input int erej);
      tests++;
      if ({n50, n100, n200, nrej} !== {e50, e100, e200, erej}) begin
         failed++;
         $display("FAIL %s counts r50/r100/r200/reject: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                  name, n50, n100, n200, nrej, e50, e100, e200, erej);
      end
      tests++;
      if (overlap + adjacent !== 0) begin
         failed++;
         $display("FAIL %s pulse shape: got %0d overlapping/%0d adjacent cycles expected 0/0",
                  name, overlap, adjacent);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_raw(3'($urandom));
         accept_en = 1'b1;
         tick();
         tests++;
         if ({r50, r100, r200, reject} !== 4'b0000 || state !== IDLE) begin
            failed++;
            $display("FAIL reset_hold: got outputs %b state %0d expected 0000 state %0d",
                     {r50, r100, r200, reject}, state, IDLE);
         end
      end
      set_raw(3'b000);
      rst = 1'b1;
      reset_counts();
      tick(20);
      check_counts("reset_idle", 0, 0, 0, 0);
      tests++;
      if (state !== IDLE) begin
         failed++;
         $display("FAIL reset_idle state: got %0d expected %0d", state, IDLE);
      end
   endtask

   task automatic test_single_coin();
      int expect_cyc;
      reset_counts();
      expect_cyc = cyc + 1 + SYNC + DEB;
      coin_window(COIN_100, 10, LOW, 1'b1);
      check_counts("single_r100", 0, 1, 0, 0);
      tests++;
      if (first_cyc !== expect_cyc) begin
         failed++;
         $display("FAIL single_r100 latency: pulse after edge %0d expected after edge %0d", first_cyc, expect_cyc);
      end
   endtask

   task automatic test_bounce();
      logic pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      reset_counts();
      accept_en = 1'b1;
      foreach (pattern[i]) begin
         set_raw({2'b00, pattern[i]});
         tick();
      end
      tests++;
      if (n50 + n100 + n200 + nrej !== 0) begin
         failed++;
         $display("FAIL bounce_quiet: got %0d pulses during bounce expected 0", n50 + n100 + n200 + nrej);
      end
      coin_window(COIN_50, 8, LOW, 1'b1);
      check_counts("bounce_r50", 1, 0, 0, 0);
   endtask

   task automatic test_multi_coin();
      reset_counts();
      coin_window(COIN_50 | COIN_200, 8, LOW, 1'b1);
      check_counts("multi_reject", 0, 0, 0, 1);
   endtask

   task automatic test_accept_en();
      reset_counts();
      coin_window(COIN_200, 8, LOW, 1'b0);
      check_counts("accept_off", 0, 0, 0, 1);
      reset_counts();
      coin_window(COIN_200, 8, LOW, 1'b1);
      check_counts("accept_on", 0, 0, 1, 0);
   endtask

   task automatic test_threshold();
      reset_counts();
      coin_window(COIN_50, DEB, LOW, 1'b1);
      check_counts("hold_short", 0, 0, 0, 0);
      reset_counts();
      coin_window(COIN_50, DEB + 1, LOW, 1'b1);
      check_counts("hold_min", 1, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      int period;
      period = 2 * DEB + SYNC + 2;
      reset_counts();
      coin_window(COIN_50, DEB + 1, period - (DEB + 1), 1'b1);
      coin_window(COIN_200, DEB + 1, LOW, 1'b1);
      check_counts("back_to_back", 1, 0, 1, 0);
   endtask

   task automatic test_hold_forever();
      reset_counts();
      accept_en = 1'b1;
      set_raw(COIN_100);
      tick(40);
      accept_en = 1'b0;
      tick(5);
      tests++;
      if (state !== RELEASE) begin
         failed++;
         $display("FAIL hold_forever state: got %0d expected %0d", state, RELEASE);
      end
      set_raw(3'b000);
      tick(LOW);
      check_counts("hold_forever", 0, 1, 0, 0);
      tests++;
      if (state !== IDLE) begin
         failed++;
         $display("FAIL hold_forever idle: got %0d expected %0d", state, IDLE);
      end
   endtask

   task automatic test_reset_mid_debounce();
      reset_counts();
      accept_en = 1'b1;
      set_raw(COIN_100);
      tick(4);
      tests++;
      if (state !== DEBOUNCE) begin
         failed++;
         $display("FAIL mid_rst precondition: got state %0d expected %0d", state, DEBOUNCE);
      end
      rst = 1'b0;
      tick(2);
      tests++;
      if (state !== IDLE || {r50, r100, r200, reject} !== 4'b0000) begin
         failed++;
         $display("FAIL mid_rst during reset: got state %0d outputs %b expected %0d 0000",
                  state, {r50, r100, r200, reject}, IDLE);
      end
      rst = 1'b1;
      tick(3);
      set_raw(3'b000);
      tick(20);
      check_counts("mid_rst", 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [2:0] multi [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
      for (int it = 0; it < 24; it++) begin
         logic [2:0] bits;
         int         hold, kind, e50, e100, e200, erej;
         logic       acc;
         kind = int'($urandom_range(0, 2));
         acc  = 1'($urandom);
         case (kind)
            0: begin
               bits = 3'($urandom_range(1, 7));
               hold = int'($urandom_range(1, DEB));
            end
            1: begin
               bits = 3'b001 << $urandom_range(0, 2);
               hold = int'($urandom_range(DEB + 1, 12));
            end
            default: begin
               bits = multi[$urandom_range(0, 3)];
               hold = int'($urandom_range(DEB + 1, 12));
            end
         endcase
         model(bits, hold, acc, e50, e100, e200, erej);
         reset_counts();
         accept_en = acc;
         set_raw(bits);
         tick(hold);
         set_raw(3'b000);
         tick(3);
         accept_en = ~acc;
         tick(LOW - 3);
         check_counts($sformatf("random_%0d", it), e50, e100, e200, erej);
      end
   endtask

   initial begin
      reset_counts();
      test_reset();
      test_single_coin();
      test_bounce();
      test_multi_coin();
      test_accept_en();
      test_threshold();
      test_back_to_back();
      test_hold_forever();
      test_reset_mid_debounce();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
